// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads instruction
// memory (combinational return), and buffers {pc, instruction} pairs in a
// small circular prefetch queue. Decode drains the queue over valid/ready.
// A redirect from execute flushes the queue and reloads the PC.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A redirect hides the head entry so nothing stale is consumed during the flush.
    assign out_valid = ~empty & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = fetch_en & ~redirect_valid & (~full | pop);

    assign imem_addr = pc;
    assign q_count   = count;
    assign out_instr = empty ? '0 : q_instr[rd_ptr];
    assign out_pc    = empty ? '0 : q_pc[rd_ptr];

    // Program counter: redirect has priority, otherwise advance on each push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: capture the fetched word together with its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= imem_rd;
            q_pc[wr_ptr]    <= pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_rd, out_instr, out_pc;
    logic        out_valid;
    logic [2:0]  q_count;

    logic        w_ready = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic [31:0] w_imem_addr, w_imem_rd, w_out_instr, w_out_pc;
    logic        w_out_valid;
    logic [2:0]  w_q_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rd   = memf(imem_addr);
    assign w_imem_rd = memf(w_imem_addr);

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_rd(imem_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .q_count(q_count)
    );

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(w_imem_addr),
        .imem_rd(w_imem_rd), .out_valid(w_out_valid), .out_ready(w_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .redirect_valid(w_redirect),
        .redirect_pc(w_redirect_pc), .q_count(w_q_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch address and a FIFO of {pc, instr} pairs.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_pc = 32'h0;
        end else begin
            bit dv, dpop, dpush;
            ent_t e;
            dv    = (mq.size() > 0) && !redirect_valid;
            dpop  = dv && out_ready;
            dpush = fetch_en && !redirect_valid && ((mq.size() < 4) || dpop);
            if (redirect_valid) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (dpop) void'(mq.pop_front());
                if (dpush) begin
                    e.pc  = m_pc;
                    e.ins = memf(m_pc);
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Every-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            logic [31:0] epc, ein;
            logic        ev;
            ev  = (mq.size() > 0) && !redirect_valid;
            epc = (mq.size() > 0) ? mq[0].pc : 32'h0;
            ein = (mq.size() > 0) ? mq[0].ins : 32'h0;
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_q_count", {29'h0, q_count}, mq.size());
            chk("m_out_valid", {31'h0, out_valid}, {31'h0, ev});
            chk("m_out_pc", out_pc, epc);
            chk("m_out_instr", out_instr, ein);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) cyc();

        // Reset state, then release with fetching and decode ready.
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_count", {29'h0, q_count}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_w_addr", w_imem_addr, 32'hFFFF_FFF8);
        rst = 1'b1;
        cyc();
        chk("s1_pc0", out_pc, 32'h0);
        chk("s1_instr0", out_instr, memf(32'h0));
        chk("s1_addr", imem_addr, 32'h4);
        chk("wrap_pc0", w_out_pc, 32'hFFFF_FFF8);
        cyc();
        chk("s1_pc1", out_pc, 32'h4);
        chk("s1_valid", {31'h0, out_valid}, 32'h1);
        chk("wrap_pc1", w_out_pc, 32'hFFFF_FFFC);
        cyc();
        chk("s1_pc2", out_pc, 32'h8);
        chk("wrap_pc2", w_out_pc, 32'h0);
        chk("wrap_addr", w_imem_addr, 32'h4);

        // Backpressure fills the queue, then drains without gaps.
        out_ready = 1'b0;
        pulse_reset();
        repeat (10) cyc();
        chk("full_count", {29'h0, q_count}, 32'h4);
        chk("full_addr", imem_addr, 32'h10);
        out_ready = 1'b1;
        #1;
        chk("drain_pc0", out_pc, 32'h0);
        cyc();
        chk("fullpop_count", {29'h0, q_count}, 32'h4);
        chk("fullpop_addr", imem_addr, 32'h14);
        chk("drain_pc1", out_pc, 32'h4);
        cyc();
        chk("drain_pc2", out_pc, 32'h8);
        cyc();
        chk("drain_pc3", out_pc, 32'hC);
        cyc();
        chk("drain_pc4", out_pc, 32'h10);

        // Redirect with three entries queued.
        out_ready = 1'b0;
        pulse_reset();
        repeat (3) cyc();
        chk("pre_redir_count", {29'h0, q_count}, 32'h3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0123;
        out_ready      = 1'b1;
        #1;
        chk("redir_valid0", {31'h0, out_valid}, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("redir_count", {29'h0, q_count}, 32'h0);
        chk("redir_addr", imem_addr, 32'h120);
        chk("redir_valid1", {31'h0, out_valid}, 32'h0);
        cyc();
        chk("redir_out_pc", out_pc, 32'h120);
        chk("redir_valid2", {31'h0, out_valid}, 32'h1);

        // Back-to-back redirects: the later one wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cyc();
        redirect_pc    = 32'h80;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("b2b_addr", imem_addr, 32'h80);
        chk("b2b_count", {29'h0, q_count}, 32'h0);
        cyc();
        chk("b2b_out_pc", out_pc, 32'h80);

        // Fetch disabled: queue drains, pc holds, redirect still loads pc.
        fetch_en = 1'b0;
        cyc();
        chk("noen_count", {29'h0, q_count}, 32'h0);
        chk("noen_addr", imem_addr, 32'h84);
        chk("noen_valid", {31'h0, out_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        chk("noen_redir_addr", imem_addr, 32'h200);
        cyc();
        chk("noen_hold_addr", imem_addr, 32'h200);
        chk("noen_hold_count", {29'h0, q_count}, 32'h0);

        // Asynchronous reset between clock edges.
        fetch_en = 1'b1;
        repeat (3) cyc();
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", {31'h0, out_valid}, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_count", {29'h0, q_count}, 32'h0);
        chk("async_w_addr", w_imem_addr, 32'hFFFF_FFF8);
        #1;
        rst = 1'b1;
        cyc();
        chk("async_first_pc", out_pc, 32'h0);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
